uart_pkt_tx_sched: RTL
======================

// Module: uart_pkt_tx_sched
// PURPOSE
//  Packet scheduler on the read side of the async_fifo in the rd_clk domain.
//  On a start command it frames one UART packet: SOF, LEN, LEN payload bytes popped
//  from the FIFO, then an XOR checksum. It hands each byte to the UART transmitter
//  over a valid/ready handshake. A FIFO that stays empty past a timeout is padded
//  and flagged.
// PARAMETERS
//  DATA_WIDTH  8                    byte width; must match the FIFO DATA_WIDTH
//  MAX_LEN     16                   maximum payload bytes per packet
//  LEN_W       $clog2(MAX_LEN+1)    width of cfg_len
//  SOF_BYTE    8'hA5                start-of-frame byte
//  PAD_BYTE    8'h00                substitute byte on underrun
//  TIMEOUT     255                  idle cycles in FETCH before underrun (>=1)
// PORTS
//  clk              in   1           single clock (the FIFO rd_clk)
//  rst_n            in   1           synchronous reset, active-low
//  start            in   1           request one packet; sampled only in IDLE
//  cfg_len          in   LEN_W       payload length; sampled with start
//  busy             out  1           high from the cycle after start is accepted until DONE exits
//  done             out  1           1-cycle pulse after the checksum byte is accepted
//  underrun         out  1           sticky; set on timeout, cleared on the next accepted start
//  fifo_rd_en       out  1           FIFO read_en
//  fifo_empty       in   1           FIFO empty
//  fifo_data        in   DATA_WIDTH  FIFO data_out
//  fifo_data_valid  in   1           FIFO data_valid; arrives 1 cycle after the read
//  tx_data          out  DATA_WIDTH  byte to the UART TX
//  tx_valid         out  1           tx_data is valid
//  tx_ready         in   1           UART TX accepts the byte
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE; all outputs 0; counters 0; underrun cleared.
//    Reset applies mid-packet. Bytes already popped are lost and no partial checksum is sent.
//  - States: IDLE, SOF, LEN, FETCH, WAIT_DV, PAYLOAD, CSUM, DONE.
//  - IDLE: if start=1, latch len = min(cfg_len, MAX_LEN), clear underrun, go to SOF.
//    start is ignored in every other state.
//  - Byte transfer happens at a posedge with tx_valid & tx_ready. tx_valid may be high
//    in SOF, LEN, PAYLOAD and CSUM only.
//  - tx_data and tx_valid hold stable until the byte is accepted. tx_valid never drops
//    without acceptance.
//  - SOF: tx_data=SOF_BYTE. On accept, go to LEN.
//  - LEN: tx_data=len, zero-extended. csum<=len. On accept, go to FETCH if len>0,
//    else go to CSUM.
//  - FETCH: fifo_rd_en = !fifo_empty, combinational and only in this state.
//    - If fifo_rd_en=1, go to WAIT_DV. Exactly one pop per payload byte.
//    - While empty, the timeout counter increments.
//    - When the counter reaches TIMEOUT: set underrun and go to PAYLOAD with PAD_BYTE.
//      No pop occurs.
//    - The counter clears on leaving FETCH.
//  - Latched underrun: every later payload byte of this packet is PAD_BYTE. FETCH is
//    bypassed and no further pops occur.
//  - WAIT_DV: on fifo_data_valid, capture fifo_data into tx_data and go to PAYLOAD.
//  - PAYLOAD: tx_valid=1. On accept: csum ^= tx_data and increment the byte count.
//    Then go to CSUM if count==len, else continue with the next byte (FETCH, or PAD
//    after underrun).
//  - CSUM: tx_data = csum, the XOR of LEN and all payload/pad bytes (SOF excluded).
//    On accept, go to DONE.
//  - DONE: done=1 for one cycle, busy=0 next cycle, go to IDLE. A start can be
//    accepted on the cycle after DONE.
//  - Widths: byte count and len are LEN_W bits. The timeout counter is
//    $clog2(TIMEOUT+1) bits. There is no wrap.
//  - Minimum packet time with tx_ready=1 and FIFO pre-filled: 3 + 3*len cycles plus DONE.
// TESTING
//  1. FIFO holds 11,22,33; cfg_len=3; tx_ready=1.
//     -> tx bytes A5,03,11,22,33,03; three fifo_rd_en pulses; one done pulse; underrun=0.
//  2. cfg_len=0 -> tx bytes A5,00,00; no fifo_rd_en; done pulses.
//  3. Packet of test 1 with tx_ready held low 5 cycles on byte 22.
//     -> tx_data/tx_valid stable through the stall; no extra fifo_rd_en; same byte stream.
//  4. TIMEOUT=8; FIFO holds only 5A; cfg_len=4.
//     -> A5,04,5A,00,00,00,5E; underrun=1 after 8 empty cycles; one pop total.
//  5. cfg_len=20 with 16+ bytes queued -> LEN byte 10; exactly 16 pops; correct XOR.
//  6. Reset mid-PAYLOAD, then start with cfg_len=1 and FIFO holding 7E.
//     -> all outputs 0 during reset; then A5,01,7E,7F; start pulsed while busy is ignored.

Source files
------------

// File: rtl/uart_pkt_tx_sched_if.sv
// FIFO read-side and UART TX byte handshake bundle for the packet scheduler.
interface uart_pkt_tx_sched_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_rd_en;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_data_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (
    output fifo_rd_en,
    input  fifo_empty, fifo_data, fifo_data_valid,
    output tx_data, tx_valid,
    input  tx_ready
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_empty, fifo_data, fifo_data_valid,
    input  tx_data, tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_pkt_tx_sched.sv
// Frames SOF, LEN, payload popped from the FIFO and an XOR checksum onto the UART TX handshake.
// state     | meaning
// S_IDLE    | waiting for start
// S_SOF     | offering SOF_BYTE
// S_LEN     | offering the clamped length
// S_FETCH   | popping the next payload byte, timing out if the FIFO stays empty
// S_WAIT_DV | waiting for the popped byte to arrive
// S_PAYLOAD | offering a payload or pad byte
// S_CSUM    | offering the checksum
// S_DONE    | one-cycle completion pulse
module uart_pkt_tx_sched #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    MAX_LEN    = 16,
  parameter int                    LEN_W      = $clog2(MAX_LEN + 1),
  parameter logic [DATA_WIDTH-1:0] SOF_BYTE   = DATA_WIDTH'(8'hA5),
  parameter logic [DATA_WIDTH-1:0] PAD_BYTE   = DATA_WIDTH'(8'h00),
  parameter int                    TIMEOUT    = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_W-1:0]     cfg_len,
  output logic                 busy,
  output logic                 done,
  output logic                 underrun,
  uart_pkt_tx_sched_if.master  bus
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SOF, S_LEN, S_FETCH, S_WAIT_DV, S_PAYLOAD, S_CSUM, S_DONE
  } state_t;

  state_t                state, state_nxt;
  logic [LEN_W-1:0]      len_q, cnt_q;
  logic [DATA_WIDTH-1:0] csum_q, byte_q;
  logic [TMO_W-1:0]      tmo_q;
  logic                  underrun_q;
  logic                  accept, last_byte, tmo_hit;

  assign accept    = bus.tx_valid & bus.tx_ready;
  assign last_byte = (cnt_q + LEN_W'(1)) == len_q;
  // The TIMEOUT-th consecutive empty cycle in FETCH is the one that gives up.
  assign tmo_hit   = bus.fifo_empty && (tmo_q == TMO_W'(TIMEOUT - 1));

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign underrun = underrun_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.tx_valid   = 1'b0;
    bus.tx_data    = '0;
    bus.fifo_rd_en = 1'b0;
    case (state)
      S_IDLE:    if (start) state_nxt = S_SOF;
      S_SOF: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = SOF_BYTE;
        if (accept) state_nxt = S_LEN;
      end
      S_LEN: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = DATA_WIDTH'(len_q);
        if (accept) state_nxt = (len_q == '0) ? S_CSUM : S_FETCH;
      end
      S_FETCH: begin
        bus.fifo_rd_en = !bus.fifo_empty;
        if (!bus.fifo_empty) state_nxt = S_WAIT_DV;
        else if (tmo_hit)    state_nxt = S_PAYLOAD;
      end
      S_WAIT_DV: if (bus.fifo_data_valid) state_nxt = S_PAYLOAD;
      S_PAYLOAD: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = byte_q;
        if (accept) begin
          if (last_byte)       state_nxt = S_CSUM;
          else if (underrun_q) state_nxt = S_PAYLOAD;
          else                 state_nxt = S_FETCH;
        end
      end
      S_CSUM: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = csum_q;
        if (accept) state_nxt = S_DONE;
      end
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q      <= '0;
      cnt_q      <= '0;
      csum_q     <= '0;
      byte_q     <= '0;
      tmo_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          len_q      <= (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
          cnt_q      <= '0;
          underrun_q <= 1'b0;
        end
        S_LEN: if (accept) csum_q <= DATA_WIDTH'(len_q);
        S_FETCH: begin
          if (!bus.fifo_empty) tmo_q <= '0;
          else if (tmo_hit) begin
            tmo_q      <= '0;
            underrun_q <= 1'b1;
            byte_q     <= PAD_BYTE;
          end else tmo_q <= tmo_q + TMO_W'(1);
        end
        S_WAIT_DV: if (bus.fifo_data_valid) byte_q <= bus.fifo_data;
        S_PAYLOAD: if (accept) begin
          csum_q <= csum_q ^ byte_q;
          cnt_q  <= cnt_q + LEN_W'(1);
          // Once underrun is latched the rest of the packet is padding without FETCH.
          if (underrun_q) byte_q <= PAD_BYTE;
        end
        default: ;
      endcase
    end
  end

endmodule
